ecc_result_buffer: RTL and testbench

Downstream stage of the ECC encoder/decoder top. Captures each completed operation (data_out, num_of_errors) on the operation_done pulse into a small FIFO. Presents results to the consumer over a valid/ready handshake. Keeps saturating operation and error statistics, so software and the bench can drain results without losing back-to-back operations.

---
 rtl/ecc_result_pkg.sv | 20 ++
 rtl/ecc_result_fifo_mem.sv | 66 ++++++
 rtl/ecc_result_buffer.sv | 118 +++++++++++
 tb/tb_ecc_result_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ecc_result_pkg.sv
// Shared constants and entry layout for the ECC result buffer.
// Optional capture timestamp enabled by defining ECC_RESULT_TIMESTAMP_EN.
package ecc_result_pkg;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_SINGLE = 2'b01;
   localparam logic [1:0] ERR_DOUBLE = 2'b10;

   localparam int TS_WIDTH = 16;

   // Entry layout, LSB first: data word, error class, then optional timestamp.
   function automatic int entry_width(input int data_w);
`ifdef ECC_RESULT_TIMESTAMP_EN
      return data_w + 2 + TS_WIDTH;
`else
      return data_w + 2;
`endif
   endfunction

endpackage

// File: rtl/ecc_result_fifo_mem.sv
// First-word-fall-through FIFO storage with exact occupancy count.
// When empty, the read port holds the last popped entry.
module ecc_result_fifo_mem #(
   parameter int W     = 34,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_wr_data,
   output logic [W-1:0]  o_rd_data,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [W-1:0]  r_last;

   logic w_pop_ok;
   logic w_push_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == LP_FULL);
   assign w_pop_ok  = i_pop & ~o_empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_push_ok = i_push & (~o_full | w_pop_ok);

   assign o_count   = r_count;
   assign o_rd_data = o_empty ? r_last : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr];
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ecc_result_buffer.sv
// Captures ECC encoder/decoder results into a FWFT FIFO with saturating stats.
// Define ECC_RESULT_TIMESTAMP_EN to store a 16-bit capture timestamp per entry.
module ecc_result_buffer
   import ecc_result_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    operation_done,
   input  logic [DATA_WIDTH-1:0]   data_out,
   input  logic [1:0]              num_of_errors,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [DATA_WIDTH-1:0]   res_data,
   output logic [1:0]              res_errs,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    overflow,
   input  logic                    clr_stats,
   output logic [CNT_WIDTH-1:0]    cnt_ops,
   output logic [CNT_WIDTH-1:0]    cnt_single,
   output logic [CNT_WIDTH-1:0]    cnt_double
`ifdef ECC_RESULT_TIMESTAMP_EN
   ,
   output logic [TS_WIDTH-1:0]     res_ts
`endif
);

   localparam int EW = entry_width(DATA_WIDTH);
   localparam int CW = $clog2(DEPTH) + 1;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [EW-1:0] w_wr_entry;
   logic [EW-1:0] w_rd_entry;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_drop;

   logic                 r_overflow;
   logic [CNT_WIDTH-1:0] r_cnt_ops;
   logic [CNT_WIDTH-1:0] r_cnt_single;
   logic [CNT_WIDTH-1:0] r_cnt_double;

`ifdef ECC_RESULT_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] r_ts;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_ts <= '0;
      else
         r_ts <= r_ts + 1'b1;
   end

   assign w_wr_entry = {r_ts, num_of_errors, data_out};
   assign res_ts     = w_rd_entry[DATA_WIDTH+2 +: TS_WIDTH];
`else
   assign w_wr_entry = {num_of_errors, data_out};
`endif

   assign w_pop  = res_ready & ~w_empty;
   // Full implies a valid head, so only a same-cycle pop can rescue the push.
   assign w_drop = operation_done & w_full & ~w_pop;

   ecc_result_fifo_mem #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (operation_done),
      .i_pop     (w_pop),
      .i_wr_data (w_wr_entry),
      .o_rd_data (w_rd_entry),
      .o_count   (w_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign res_valid  = ~w_empty;
   assign res_data   = w_rd_entry[DATA_WIDTH-1:0];
   assign res_errs   = w_rd_entry[DATA_WIDTH +: 2];
   assign fifo_count = w_count;
   assign overflow   = r_overflow;
   assign cnt_ops    = r_cnt_ops;
   assign cnt_single = r_cnt_single;
   assign cnt_double = r_cnt_double;

   // clr_stats wins over a coincident capture; the FIFO push itself is unaffected.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow   <= 1'b0;
         r_cnt_ops    <= '0;
         r_cnt_single <= '0;
         r_cnt_double <= '0;
      end else if (clr_stats) begin
         r_overflow   <= 1'b0;
         r_cnt_ops    <= '0;
         r_cnt_single <= '0;
         r_cnt_double <= '0;
      end else if (operation_done) begin
         r_cnt_ops <= sat_inc(r_cnt_ops);
         if (num_of_errors == ERR_SINGLE)
            r_cnt_single <= sat_inc(r_cnt_single);
         if ((num_of_errors & ERR_DOUBLE) == ERR_DOUBLE)
            r_cnt_double <= sat_inc(r_cnt_double);
         if (w_drop)
            r_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ecc_result_buffer.sv
// Directed, table-driven bench for ecc_result_buffer (DEPTH=4, 4-bit counters).
module tb_ecc_result_buffer;

   localparam int DW = 32;
   localparam int DP = 4;
   localparam int CN = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          operation_done = 1'b0;
   logic [DW-1:0] data_out = '0;
   logic [1:0]    num_of_errors = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [DW-1:0] res_data;
   logic [1:0]    res_errs;
   logic [2:0]    fifo_count;
   logic          overflow;
   logic          clr_stats = 1'b0;
   logic [CN-1:0] cnt_ops;
   logic [CN-1:0] cnt_single;
   logic [CN-1:0] cnt_double;
`ifdef ECC_RESULT_TIMESTAMP_EN
   logic [15:0]   res_ts;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ecc_result_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DP),
      .CNT_WIDTH  (CN)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .operation_done (operation_done),
      .data_out       (data_out),
      .num_of_errors  (num_of_errors),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_data       (res_data),
      .res_errs       (res_errs),
      .fifo_count     (fifo_count),
      .overflow       (overflow),
      .clr_stats      (clr_stats),
      .cnt_ops        (cnt_ops),
      .cnt_single     (cnt_single),
`ifdef ECC_RESULT_TIMESTAMP_EN
      .res_ts         (res_ts),
`endif
      .cnt_double     (cnt_double)
   );

   typedef struct {
      logic          od;
      logic [DW-1:0] d;
      logic [1:0]    e;
      logic          rdy;
      logic          clr;
      logic          xv;
      logic [2:0]    xcnt;
      logic          xovf;
      logic [CN-1:0] xops;
      logic [CN-1:0] xsgl;
      logic [CN-1:0] xdbl;
      logic [DW-1:0] xd;
      logic [1:0]    xe;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic od, input logic [DW-1:0] d, input logic [1:0] e,
                      input logic rdy, input logic clr, input logic xv,
                      input logic [2:0] xcnt, input logic xovf,
                      input logic [CN-1:0] xops, input logic [CN-1:0] xsgl,
                      input logic [CN-1:0] xdbl, input logic [DW-1:0] xd,
                      input logic [1:0] xe);
      vec_t v;
      v.od = od; v.d = d; v.e = e; v.rdy = rdy; v.clr = clr;
      v.xv = xv; v.xcnt = xcnt; v.xovf = xovf;
      v.xops = xops; v.xsgl = xsgl; v.xdbl = xdbl; v.xd = xd; v.xe = xe;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " valid"},  32'(res_valid),  32'd0);
      check({tag, " data"},   res_data,        32'd0);
      check({tag, " errs"},   32'(res_errs),   32'd0);
      check({tag, " count"},  32'(fifo_count), 32'd0);
      check({tag, " ovf"},    32'(overflow),   32'd0);
      check({tag, " ops"},    32'(cnt_ops),    32'd0);
      check({tag, " single"}, 32'(cnt_single), 32'd0);
      check({tag, " double"}, 32'(cnt_double), 32'd0);
   endtask

   initial begin
      // od   data        e      rdy  clr  | v  cnt ovf ops sgl dbl  head data   head e
      // three captures held, then drained in order
      add(1, 32'h11, 2'b00, 0, 0,  1, 3'd1, 0, 4'd1, 4'd0, 4'd0, 32'h11, 2'b00);
      add(1, 32'h22, 2'b01, 0, 0,  1, 3'd2, 0, 4'd2, 4'd1, 4'd0, 32'h11, 2'b00);
      add(1, 32'h33, 2'b10, 0, 0,  1, 3'd3, 0, 4'd3, 4'd1, 4'd1, 32'h11, 2'b00);
      add(0, 32'h0,  2'b00, 1, 0,  1, 3'd2, 0, 4'd3, 4'd1, 4'd1, 32'h22, 2'b01);
      add(0, 32'h0,  2'b00, 1, 0,  1, 3'd1, 0, 4'd3, 4'd1, 4'd1, 32'h33, 2'b10);
      add(0, 32'h0,  2'b00, 1, 0,  0, 3'd0, 0, 4'd3, 4'd1, 4'd1, 32'h0,  2'b00);
      add(0, 32'h0,  2'b00, 0, 1,  0, 3'd0, 0, 4'd0, 4'd0, 4'd0, 32'h0,  2'b00);
      // five pushes into four entries: last one dropped, still counted
      add(1, 32'hA1, 2'b00, 0, 0,  1, 3'd1, 0, 4'd1, 4'd0, 4'd0, 32'hA1, 2'b00);
      add(1, 32'hA2, 2'b00, 0, 0,  1, 3'd2, 0, 4'd2, 4'd0, 4'd0, 32'hA1, 2'b00);
      add(1, 32'hA3, 2'b11, 0, 0,  1, 3'd3, 0, 4'd3, 4'd0, 4'd1, 32'hA1, 2'b00);
      add(1, 32'hA4, 2'b01, 0, 0,  1, 3'd4, 0, 4'd4, 4'd1, 4'd1, 32'hA1, 2'b00);
      add(1, 32'hA5, 2'b01, 0, 0,  1, 3'd4, 1, 4'd5, 4'd2, 4'd1, 32'hA1, 2'b00);
      // clear stats, then push+pop while full
      add(0, 32'h0,  2'b00, 0, 1,  1, 3'd4, 0, 4'd0, 4'd0, 4'd0, 32'hA1, 2'b00);
      add(1, 32'hB6, 2'b10, 1, 0,  1, 3'd4, 0, 4'd1, 4'd0, 4'd1, 32'hA2, 2'b00);
      add(0, 32'h0,  2'b00, 1, 0,  1, 3'd3, 0, 4'd1, 4'd0, 4'd1, 32'hA3, 2'b11);
      add(0, 32'h0,  2'b00, 1, 0,  1, 3'd2, 0, 4'd1, 4'd0, 4'd1, 32'hA4, 2'b01);
      add(0, 32'h0,  2'b00, 1, 0,  1, 3'd1, 0, 4'd1, 4'd0, 4'd1, 32'hB6, 2'b10);
      add(0, 32'h0,  2'b00, 1, 0,  0, 3'd0, 0, 4'd1, 4'd0, 4'd1, 32'h0,  2'b00);
      // push with ready while empty
      add(1, 32'hC7, 2'b00, 1, 0,  1, 3'd1, 0, 4'd2, 4'd0, 4'd1, 32'hC7, 2'b00);
      add(0, 32'h0,  2'b00, 1, 0,  0, 3'd0, 0, 4'd2, 4'd0, 4'd1, 32'h0,  2'b00);
      // clear coincident with a single-error capture
      add(1, 32'hD8, 2'b01, 0, 1,  1, 3'd1, 0, 4'd0, 4'd0, 4'd0, 32'hD8, 2'b01);
      add(1, 32'hD9, 2'b10, 0, 0,  1, 3'd2, 0, 4'd1, 4'd0, 4'd1, 32'hD8, 2'b01);

      // reset state
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("post_reset");

      for (int i = 0; i < vq.size(); i++) begin
         operation_done = vq[i].od;
         data_out       = vq[i].d;
         num_of_errors  = vq[i].e;
         res_ready      = vq[i].rdy;
         clr_stats      = vq[i].clr;
         @(posedge clk);
         #1;
         check($sformatf("v%0d valid", i),  32'(res_valid),  32'(vq[i].xv));
         check($sformatf("v%0d count", i),  32'(fifo_count), 32'(vq[i].xcnt));
         check($sformatf("v%0d ovf", i),    32'(overflow),   32'(vq[i].xovf));
         check($sformatf("v%0d ops", i),    32'(cnt_ops),    32'(vq[i].xops));
         check($sformatf("v%0d single", i), 32'(cnt_single), 32'(vq[i].xsgl));
         check($sformatf("v%0d double", i), 32'(cnt_double), 32'(vq[i].xdbl));
         if (vq[i].xv) begin
            check($sformatf("v%0d data", i), res_data,       vq[i].xd);
            check($sformatf("v%0d errs", i), 32'(res_errs),  32'(vq[i].xe));
         end
      end

      // mid-drain asynchronous reset
      operation_done = 1'b0;
      clr_stats      = 1'b0;
      res_ready      = 1'b1;
      @(posedge clk);
      #1;
      check("drain count", 32'(fifo_count), 32'd1);
      check("drain data",  res_data,        32'hD9);
      check("drain errs",  32'(res_errs),   32'd2);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      res_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // counter saturation: 17 captures, 4-bit counters stop at 15
      res_ready     = 1'b1;
      operation_done = 1'b1;
      num_of_errors = 2'b01;
      for (int k = 0; k < 17; k++) begin
         data_out = 32'h100 + 32'(k);
         @(posedge clk);
         #1;
      end
      operation_done = 1'b0;
      res_ready      = 1'b0;
      check("sat ops",    32'(cnt_ops),    32'd15);
      check("sat single", 32'(cnt_single), 32'd15);
      check("sat double", 32'(cnt_double), 32'd0);
      check("sat count",  32'(fifo_count), 32'd1);
      check("sat ovf",    32'(overflow),   32'd0);
      check("sat data",   res_data,        32'h110);
      check("sat valid",  32'(res_valid),  32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
